nibble_serial_addsub: RTL and testbench



---
 rtl/nibble_serial_addsub_pkg.sv | 15 +
 rtl/nibble_addsub_slice.sv | 32 +++
 rtl/nibble_serial_addsub.sv | 116 +++++++++++
 tb/tb_nibble_serial_addsub.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_addsub_pkg.sv
// Shared constants and state encoding for the nibble-serial add/sub datapath.
package nibble_serial_addsub_pkg;

   localparam int NIBBLE_W = 4;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/nibble_addsub_slice.sv
// Combinational 4-bit ripple add/sub slice; cin is separate from m so the
// inter-nibble carry can be chained across cycles.
module nibble_addsub_slice
   import nibble_serial_addsub_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                m,
   input  logic                cin,
   output logic [NIBBLE_W-1:0] s,
   output logic                c3,
   output logic                c4
);

   logic [NIBBLE_W-1:0] b_eff;
   logic [NIBBLE_W:0]   c;

   // Subtraction inverts B here; the +1 arrives through cin on nibble 0.
   always_comb begin
      b_eff = (m == OP_SUB) ? ~b : b;
      c     = '0;
      s     = '0;
      c[0]  = cin;
      for (int i = 0; i < NIBBLE_W; i++) begin
         s[i]   = a[i] ^ b_eff[i] ^ c[i];
         c[i+1] = (a[i] & b_eff[i]) | (a[i] & c[i]) | (b_eff[i] & c[i]);
      end
      c3 = c[NIBBLE_W-1];
      c4 = c[NIBBLE_W];
   end

endmodule

// File: rtl/nibble_serial_addsub.sv
// Multi-nibble two's-complement adder/subtractor: one 4-bit slice per clock,
// LSB nibble first, with the carry held in a register between nibbles.
module nibble_serial_addsub
   import nibble_serial_addsub_pkg::*;
#(
   parameter int NIBBLES = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [NIBBLE_W*NIBBLES-1:0] op_a,
   input  logic [NIBBLE_W*NIBBLES-1:0] op_b,
   input  logic                      m,
   output logic                      in_ready,
   output logic                      busy,
   output logic                      done,
   output logic [NIBBLE_W*NIBBLES-1:0] result,
   output logic                      cout,
   output logic                      v
);

   localparam int W     = NIBBLE_W * NIBBLES;
   localparam int IDX_W = $clog2(NIBBLES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   state_t state_q, state_d;

   logic [W-1:0]     a_q, b_q, partial_q, result_q;
   logic             m_q, carry_q, cout_q, v_q;
   logic [IDX_W-1:0] idx_q;

   logic [NIBBLE_W-1:0] a_nib, b_nib, s_nib;
   logic                c3, c4;
   logic                accept, last_nib;

   assign accept   = start & in_ready;
   assign last_nib = (state_q == ST_RUN) && (idx_q == LAST_IDX);
   assign a_nib    = a_q[int'(idx_q)*NIBBLE_W +: NIBBLE_W];
   assign b_nib    = b_q[int'(idx_q)*NIBBLE_W +: NIBBLE_W];

   nibble_addsub_slice u_slice (
      .a   (a_nib),
      .b   (b_nib),
      .m   (m_q),
      .cin (carry_q),
      .s   (s_nib),
      .c3  (c3),
      .c4  (c4)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // DONE accepts a new start directly so back-to-back ops skip IDLE.
   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (start) state_d = ST_RUN;
         end
         ST_RUN: begin
            busy = 1'b1;
            if (last_nib) state_d = ST_DONE;
         end
         ST_DONE: begin
            done     = 1'b1;
            in_ready = 1'b1;
            state_d  = start ? ST_RUN : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Partial nibbles accumulate privately; result only moves on the MSB slice.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q       <= '0;
         b_q       <= '0;
         m_q       <= OP_ADD;
         carry_q   <= 1'b0;
         idx_q     <= '0;
         partial_q <= '0;
         result_q  <= '0;
         cout_q    <= 1'b0;
         v_q       <= 1'b0;
      end else if (accept) begin
         a_q     <= op_a;
         b_q     <= op_b;
         m_q     <= m;
         carry_q <= m;
         idx_q   <= '0;
      end else if (state_q == ST_RUN) begin
         partial_q[int'(idx_q)*NIBBLE_W +: NIBBLE_W] <= s_nib;
         carry_q <= c4;
         if (last_nib) begin
            idx_q    <= '0;
            result_q <= {s_nib, partial_q[W-NIBBLE_W-1:0]};
            cout_q   <= c4;
            v_q      <= c3 ^ c4;
         end else begin
            idx_q <= idx_q + 1'b1;
         end
      end
   end

   assign result = result_q;
   assign cout   = cout_q;
   assign v      = v_q;

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Directed self-checking bench for nibble_serial_addsub with NIBBLES=4.
module tb_nibble_serial_addsub;

   localparam int NIBBLES = 4;
   localparam int W       = 4 * NIBBLES;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] op_a = '0;
   logic [W-1:0] op_b = '0;
   logic         m = 1'b0;
   logic         in_ready, busy, done, cout, v;
   logic [W-1:0] result;

   int errors = 0;
   int checks = 0;

   nibble_serial_addsub #(.NIBBLES(NIBBLES)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .op_a     (op_a),
      .op_b     (op_b),
      .m        (m),
      .in_ready (in_ready),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .cout     (cout),
      .v        (v)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
      end
   endtask

   // Presents a request for exactly one rising edge, returning at the following negedge.
   task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
      start = 1'b1;
      op_a  = a;
      op_b  = b;
      m     = sub;
      @(negedge clk);
      start = 1'b0;
      op_a  = 16'hDEAD;
      op_b  = 16'hBEEF;
      m     = ~sub;
   endtask

   task automatic waitDone(output int cycles);
      cycles = 0;
      while (!done && cycles < 20) begin
         @(negedge clk);
         cycles++;
      end
   endtask

   task automatic checkIdleOutputs(input string tag);
      checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      checkOutput({tag, "_busy"},     32'(busy),     32'd0);
      checkOutput({tag, "_done"},     32'(done),     32'd0);
      checkOutput({tag, "_result"},   32'(result),   32'd0);
      checkOutput({tag, "_cout"},     32'(cout),     32'd0);
      checkOutput({tag, "_v"},        32'(v),        32'd0);
   endtask

   task automatic runOp(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic [W-1:0] expRes, input logic expC, input logic expV);
      int cyc;
      applyStimulus(a, b, sub);
      checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
      waitDone(cyc);
      checkOutput({tag, "_latency"}, 32'(cyc), 32'(NIBBLES));
      checkOutput({tag, "_result"}, 32'(result), 32'(expRes));
      checkOutput({tag, "_cout"},   32'(cout),   32'(expC));
      checkOutput({tag, "_v"},      32'(v),      32'(expV));
   endtask

   initial begin
      int cyc;
      int pulses;
      int holdBad;
      logic [W-1:0] seen;

      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkIdleOutputs("reset");

      runOp("add", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
      checkOutput("add_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      checkOutput("add_done_pulse", 32'(done), 32'd0);

      runOp("ovf",  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
      @(negedge clk);
      runOp("sub1", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      @(negedge clk);
      runOp("sub2", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
      @(negedge clk);

      // Second start issued in the DONE cycle of the first.
      runOp("wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
      applyStimulus(16'h0010, 16'h0001, 1'b1);
      checkOutput("b2b_busy", 32'(busy), 32'd1);
      cyc = 0;
      holdBad = 0;
      while (!done && cyc < 20) begin
         if (result !== 16'h0000) holdBad++;
         @(negedge clk);
         cyc++;
      end
      checkOutput("b2b_hold", 32'(holdBad), 32'd0);
      checkOutput("b2b_latency", 32'(cyc), 32'(NIBBLES));
      checkOutput("b2b_result", 32'(result), 32'h000F);
      checkOutput("b2b_cout", 32'(cout), 32'd1);
      checkOutput("b2b_v", 32'(v), 32'd0);
      @(negedge clk);

      // A start pulsed mid-run must be dropped, not queued.
      applyStimulus(16'h1111, 16'h1111, 1'b0);
      @(negedge clk);
      applyStimulus(16'h4321, 16'h0101, 1'b1);
      pulses = 0;
      seen = '0;
      for (int i = 0; i < 12; i++) begin
         if (done) begin
            pulses++;
            seen = result;
         end
         @(negedge clk);
      end
      checkOutput("ignore_pulses", 32'(pulses), 32'd1);
      checkOutput("ignore_result", 32'(seen), 32'h2222);
      checkOutput("ignore_cout", 32'(cout), 32'd0);

      // Reset during RUN aborts with no done and clears everything.
      applyStimulus(16'h0F0F, 16'h0101, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checkIdleOutputs("midrst");
      @(negedge clk);
      rst = 1'b0;
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         if (done) pulses++;
         @(negedge clk);
      end
      checkOutput("midrst_pulses", 32'(pulses), 32'd0);
      checkIdleOutputs("postrst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
